spi_mosi_rx: RTL and testbench
==============================

SPI_MOSI_RX -- requirements
Module: spi_mosi_rx

Interface
REQ-001 Parameter WIDTH, default 8, number of serial bits per received word.
REQ-002 i_CLK  input  1  system clock, the single clock domain; i_CLK frequency >= 4x SCK frequency.
REQ-003 i_RST_N  input  1  asynchronous, active-low reset.
REQ-004 i_SCK  input  1  SPI serial clock, asynchronous to i_CLK.
REQ-005 i_CS  input  1  SPI chip select, active low, asynchronous.
REQ-006 i_MOSI  input  1  serial data, MSB first, stable on SCK rising edge.
REQ-007 i_DC  input  1  data/command bit, valid with the first bit of each word.
REQ-008 i_READY  input  1  consumer accepts the word when i_READY and o_VALID are both 1 on an i_CLK edge.
REQ-009 o_DATA  output  WIDTH  received word, MSB = first bit received.
REQ-010 o_DC  output  1  D/C bit captured with o_DATA.
REQ-011 o_VALID  output  1  o_DATA/o_DC hold an unconsumed word.
REQ-012 o_BUSY  output  1  frame active (synchronized CS low).
REQ-013 o_FRAME_ERR  output  1  one-cycle pulse: CS deasserted mid-word.
REQ-014 o_OVERRUN  output  1  one-cycle pulse: completed word dropped, holding register full.

Function
REQ-015 i_SCK, i_CS, i_MOSI and i_DC SHALL each pass through a 2-flop synchronizer; reset value is 0 for SCK, MOSI and DC, and 1 for CS.
REQ-016 An SCK rising edge SHALL be detected when synchronized SCK is 1 and its registered copy is 0; MOSI and DC SHALL be sampled from the same synchronized cycle.
REQ-017 FSM states: IDLE (CS high) and SHIFT (CS low); IDLE->SHIFT on synchronized CS=0; SHIFT->IDLE on synchronized CS=1.
REQ-018 In SHIFT, each detected rising edge SHALL shift MOSI into the LSB of the shift register and increment the bit counter; the first bit of a word SHALL also latch DC.
REQ-019 On the WIDTH-th rising edge, the block SHALL load o_DATA/o_DC and assert o_VALID on the next i_CLK edge, then reset the bit counter to 0 and stay in SHIFT.
REQ-020 Back-to-back words with CS held low SHALL be received with no gap bits required.
REQ-021 o_VALID SHALL clear on the accept edge unless a new word completes in the same cycle; in that case the new word SHALL load and o_VALID SHALL stay 1.
REQ-022 If a word completes while o_VALID=1 and i_READY=0, the block SHALL drop the new word, leave o_DATA unchanged and pulse o_OVERRUN for one cycle.
REQ-023 A SHIFT->IDLE transition with bit counter != 0 SHALL discard the partial word, clear the counter and pulse o_FRAME_ERR; with counter = 0, no pulse SHALL occur.
REQ-024 SCK edges while synchronized CS=1 SHALL be ignored.
REQ-025 o_BUSY SHALL equal 1 exactly when the FSM is in SHIFT.

Reset
REQ-026 On i_RST_N=0: FSM=IDLE, counter=0, shift register=0, o_DATA=0, o_DC=0, o_VALID=0, o_BUSY=0, o_FRAME_ERR=0, o_OVERRUN=0.
REQ-027 Reset asserted mid-word SHALL abandon the word without any o_FRAME_ERR pulse; after release, reception SHALL resume only on a fresh CS-low.

Structure
REQ-028 Package spi_pkg SHALL hold the WIDTH default, the FSM state encodings and the counter width, clog2(WIDTH)+1.
REQ-029 The synchronizer SHALL be a sub-module, spi_sync2 (2-flop, parameterised reset value), instantiated four times.

Verification
REQ-030 CS low, send 0xA5 with DC=1 at SCK = i_CLK/8, i_READY=1 -> one o_VALID pulse, o_DATA=0xA5, o_DC=1, no error pulses.
REQ-031 CS held low, send 0x3C (DC=0) then 0xC3 (DC=1) back-to-back, i_READY=1 -> two words in order with matching DC, o_BUSY=1 throughout.
REQ-032 i_READY=0, send 0x11 then 0x22 -> o_DATA stays 0x11, o_OVERRUN pulses once; raise i_READY -> 0x11 accepted, o_VALID=0.
REQ-033 Send 5 bits, then raise CS -> o_FRAME_ERR pulses once, o_VALID stays 0; the next full word 0x7E is received correctly.
REQ-034 Assert i_RST_N=0 after 3 bits -> all outputs return to reset values; then send a full word 0x81 -> o_DATA=0x81 and no o_FRAME_ERR pulse.
REQ-035 Toggle SCK 8 times with CS high -> no o_VALID, o_BUSY=0.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM encoding for the SPI MOSI receiver
package spi_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/spi_mosi_rx_if.sv
// rtl/spi_mosi_rx_if.sv - serial inputs and word-level handshake of the MOSI receiver
interface spi_mosi_rx_if #(
    parameter int WIDTH = spi_pkg::WIDTH_DEFAULT
);
    logic             i_SCK;
    logic             i_CS;
    logic             i_MOSI;
    logic             i_DC;
    logic             i_READY;
    logic [WIDTH-1:0] o_DATA;
    logic             o_DC;
    logic             o_VALID;
    logic             o_BUSY;
    logic             o_FRAME_ERR;
    logic             o_OVERRUN;

    modport slave (
        input  i_SCK, i_CS, i_MOSI, i_DC, i_READY,
        output o_DATA, o_DC, o_VALID, o_BUSY, o_FRAME_ERR, o_OVERRUN
    );

    modport master (
        output i_SCK, i_CS, i_MOSI, i_DC, i_READY,
        input  o_DATA, o_DC, o_VALID, o_BUSY, o_FRAME_ERR, o_OVERRUN
    );
endinterface

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchronizer with selectable reset value
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_mosi_rx.sv
// rtl/spi_mosi_rx.sv - SPI MOSI word receiver with D/C capture, overrun and framing checks
module spi_mosi_rx
    import spi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic         i_CLK,
    input  logic         i_RST_N,
    spi_mosi_rx_if.slave bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic sck_s, cs_s, mosi_s, dc_s, sck_d;

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(i_CLK), .rst_n(i_RST_N), .d(bus.i_SCK),  .q(sck_s));
    spi_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(i_CLK), .rst_n(i_RST_N), .d(bus.i_CS),   .q(cs_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(i_CLK), .rst_n(i_RST_N), .d(bus.i_MOSI), .q(mosi_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_sync_dc   (.clk(i_CLK), .rst_n(i_RST_N), .d(bus.i_DC),   .q(dc_s));

    state_t           state, state_nxt;
    logic [1:0]       settle;
    logic             armed;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg, data_q;
    logic             dc_lat, dc_q, valid_q, fe_q, ov_q;

    logic             sck_rise, accept, word_done, word_dc;
    logic [WIDTH-1:0] word_nxt;

    assign sck_rise  = sck_s & ~sck_d;
    assign accept    = valid_q & bus.i_READY;
    assign word_nxt  = {shreg[WIDTH-2:0], mosi_s};
    assign word_dc   = (cnt == '0) ? dc_s : dc_lat;
    assign word_done = (state == ST_SHIFT) && !cs_s && sck_rise && (cnt == LAST);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (armed && !cs_s) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cs_s)           state_nxt = ST_IDLE;
        endcase
    end

    // The CS synchronizer resets to "deselected", so a CS already low at reset
    // release must first be seen high (after the chain has flushed) to arm.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd3)         settle <= settle + 2'd1;
            if (settle == 2'd3 && cs_s) armed  <= 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sck_d   <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            dc_lat  <= 1'b0;
            data_q  <= '0;
            dc_q    <= 1'b0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            sck_d <= sck_s;
            fe_q  <= 1'b0;
            ov_q  <= 1'b0;
            if (accept) valid_q <= 1'b0;

            if (state == ST_SHIFT) begin
                if (cs_s) begin
                    if (cnt != '0) fe_q <= 1'b1;
                    cnt   <= '0;
                    shreg <= '0;
                end else if (sck_rise) begin
                    shreg <= word_nxt;
                    if (cnt == '0) dc_lat <= dc_s;
                    if (word_done) begin
                        cnt <= '0;
                        // A word completing on the accept cycle replaces the one leaving.
                        if (!valid_q || bus.i_READY) begin
                            data_q  <= word_nxt;
                            dc_q    <= word_dc;
                            valid_q <= 1'b1;
                        end else begin
                            ov_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_DATA      = data_q;
    assign bus.o_DC        = dc_q;
    assign bus.o_VALID     = valid_q;
    assign bus.o_BUSY      = (state == ST_SHIFT);
    assign bus.o_FRAME_ERR = fe_q;
    assign bus.o_OVERRUN   = ov_q;
endmodule

// File: tb/tb_spi_mosi_rx.sv
// tb/tb_spi_mosi_rx.sv - directed self-checking bench for spi_mosi_rx
module tb_spi_mosi_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_mosi_rx_if #(.WIDTH(8)) bus ();

    spi_mosi_rx #(.WIDTH(8)) dut (
        .i_CLK  (clk),
        .i_RST_N(rst_n),
        .bus    (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         busy_drop = 0;
    int         idle_bad = 0;
    bit         watch_busy = 1'b0;
    bit         watch_idle = 1'b0;
    logic [7:0] acc_data[$];
    logic       acc_dc[$];

    always @(negedge clk) begin
        if (bus.o_FRAME_ERR) fe_cnt <= fe_cnt + 1;
        if (bus.o_OVERRUN)   ov_cnt <= ov_cnt + 1;
        if (bus.o_VALID && bus.i_READY) begin
            acc_data.push_back(bus.o_DATA);
            acc_dc.push_back(bus.o_DC);
        end
        if (watch_busy && !bus.o_BUSY) busy_drop <= busy_drop + 1;
        if (watch_idle && (bus.o_BUSY || bus.o_VALID)) idle_bad <= idle_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic dc);
        bus.i_MOSI = b;
        bus.i_DC   = dc;
        tick(4);
        bus.i_SCK = 1'b1;
        tick(4);
        bus.i_SCK = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input logic dc, input int n);
        logic [7:0] v;
        v = w;
        for (int i = 7; i > 7 - n; i--) send_bit(v[i], dc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  bus.o_DATA,      32'h0);
        check({tag, "_dc"},    bus.o_DC,        32'h0);
        check({tag, "_valid"}, bus.o_VALID,     32'h0);
        check({tag, "_busy"},  bus.o_BUSY,      32'h0);
        check({tag, "_fe"},    bus.o_FRAME_ERR, 32'h0);
        check({tag, "_ov"},    bus.o_OVERRUN,   32'h0);
    endtask

    int fe0, ov0, acc0;

    initial begin
        bus.i_SCK   = 1'b0;
        bus.i_CS    = 1'b1;
        bus.i_MOSI  = 1'b0;
        bus.i_DC    = 1'b0;
        bus.i_READY = 1'b1;
        tick(5);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(8);

        // single word 0xA5, DC=1
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_data.size();
        bus.i_CS = 1'b0; tick(6);
        send_bits(8'hA5, 1'b1, 8);
        tick(6);
        bus.i_CS = 1'b1; tick(8);
        check("a5_count", acc_data.size() - acc0, 1);
        if (acc_data.size() > acc0) begin
            check("a5_data", acc_data[acc0], 8'hA5);
            check("a5_dc",   acc_dc[acc0],   1);
        end
        check("a5_fe", fe_cnt - fe0, 0);
        check("a5_ov", ov_cnt - ov0, 0);

        // back-to-back words with CS held low
        fe0 = fe_cnt; acc0 = acc_data.size();
        bus.i_CS = 1'b0; tick(6);
        watch_busy = 1'b1;
        send_bits(8'h3C, 1'b0, 8);
        send_bits(8'hC3, 1'b1, 8);
        tick(6);
        watch_busy = 1'b0;
        bus.i_CS = 1'b1; tick(8);
        check("b2b_count", acc_data.size() - acc0, 2);
        if (acc_data.size() >= acc0 + 2) begin
            check("b2b_data0", acc_data[acc0],     8'h3C);
            check("b2b_dc0",   acc_dc[acc0],       0);
            check("b2b_data1", acc_data[acc0 + 1], 8'hC3);
            check("b2b_dc1",   acc_dc[acc0 + 1],   1);
        end
        check("b2b_busy", busy_drop, 0);
        check("b2b_fe", fe_cnt - fe0, 0);

        // overrun: consumer stalled across two words
        ov0 = ov_cnt; acc0 = acc_data.size();
        bus.i_READY = 1'b0;
        bus.i_CS = 1'b0; tick(6);
        send_bits(8'h11, 1'b0, 8);
        send_bits(8'h22, 1'b0, 8);
        tick(6);
        check("ovr_valid", bus.o_VALID, 1);
        check("ovr_data",  bus.o_DATA,  8'h11);
        check("ovr_pulse", ov_cnt - ov0, 1);
        bus.i_READY = 1'b1; tick(3);
        check("ovr_acc_count", acc_data.size() - acc0, 1);
        if (acc_data.size() > acc0) check("ovr_acc_data", acc_data[acc0], 8'h11);
        check("ovr_valid_clr", bus.o_VALID, 0);
        bus.i_CS = 1'b1; tick(8);

        // framing error after 5 bits, then a clean 0x7E
        fe0 = fe_cnt; acc0 = acc_data.size();
        bus.i_CS = 1'b0; tick(6);
        send_bits(8'hF8, 1'b1, 5);
        tick(4);
        bus.i_CS = 1'b1; tick(8);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_valid", bus.o_VALID, 0);
        check("fe_nodata", acc_data.size() - acc0, 0);
        bus.i_CS = 1'b0; tick(6);
        send_bits(8'h7E, 1'b0, 8);
        tick(6);
        bus.i_CS = 1'b1; tick(8);
        check("fe_next_count", acc_data.size() - acc0, 1);
        if (acc_data.size() > acc0) begin
            check("fe_next_data", acc_data[acc0], 8'h7E);
            check("fe_next_dc",   acc_dc[acc0],   0);
        end
        check("fe_next_nofe", fe_cnt - fe0, 1);

        // reset mid-word, resume only on a fresh CS-low
        fe0 = fe_cnt; acc0 = acc_data.size();
        bus.i_CS = 1'b0; tick(6);
        send_bits(8'hE0, 1'b1, 3);
        rst_n = 1'b0; tick(3);
        check_reset_outputs("midrst");
        rst_n = 1'b1; tick(10);
        check("midrst_no_resume", bus.o_BUSY, 0);
        bus.i_CS = 1'b1; tick(8);
        bus.i_CS = 1'b0; tick(6);
        send_bits(8'h81, 1'b1, 8);
        tick(6);
        check("midrst_data", bus.o_DATA, 8'h81);
        bus.i_CS = 1'b1; tick(8);
        check("midrst_count", acc_data.size() - acc0, 1);
        if (acc_data.size() > acc0) check("midrst_acc", acc_data[acc0], 8'h81);
        check("midrst_fe", fe_cnt - fe0, 0);

        // SCK activity while deselected
        acc0 = acc_data.size();
        watch_idle = 1'b1;
        send_bits(8'hFF, 1'b1, 8);
        tick(6);
        watch_idle = 1'b0;
        check("cs_hi_idle", idle_bad, 0);
        check("cs_hi_count", acc_data.size() - acc0, 0);
        check("cs_hi_busy", bus.o_BUSY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
